// File: rtl/difftest_trigger_pkg.sv
// rtl/difftest_trigger_pkg.sv - shared types, widths and helpers for the trigger-CSR capture queue
//
// Contents:
//   DROP_CNT_W          width of the saturating drop counter
//   trigger_csr_snap_t  snapshot layout at the default 64-bit CSR / 8-bit coreid widths
//   chan_idx_w()        width of a channel index (never below 1 bit)
//   sat_add()           saturating add used by the drop counter
package difftest_trigger_pkg;

  localparam int DROP_CNT_W  = 32;
  localparam int SNAP_DATA_W = 64;
  localparam int SNAP_CORE_W = 8;

  typedef struct packed {
    logic [SNAP_DATA_W-1:0] tselect;
    logic [SNAP_DATA_W-1:0] tdata1;
    logic [SNAP_DATA_W-1:0] tinfo;
    logic [SNAP_CORE_W-1:0] coreid;
  } trigger_csr_snap_t;

  function automatic int chan_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [DROP_CNT_W-1:0] sat_add(input logic [DROP_CNT_W-1:0] a,
                                                     input logic [DROP_CNT_W-1:0] b);
    logic [DROP_CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DROP_CNT_W] ? '1 : s[DROP_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/difftest_rr_arbiter.sv
// rtl/difftest_rr_arbiter.sv - round-robin grant of one pending capture slot per cycle
//
// Ports:
//   clock          sole clock
//   reset_n        asynchronous active-low reset (pointer returns to 0)
//   req_i          one request bit per channel (slot pending)
//   en_i           grant allowed this cycle (downstream can accept)
//   grant_o        one-hot grant
//   grant_idx_o    index of the granted channel
//   grant_valid_o  a grant was issued this cycle
module difftest_rr_arbiter #(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] req_i,
  input  logic              en_i,
  output logic [NUM_CH-1:0] grant_o,
  output logic [IDX_W-1:0]  grant_idx_o,
  output logic              grant_valid_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] cand;
  logic             found;

  // Scan channels starting at the pointer; the first requester wins.
  always_comb begin
    found       = 1'b0;
    grant_idx_o = '0;
    cand        = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = IDX_W'((int'(ptr_q) + i) % NUM_CH);
      if (en_i && !found && req_i[cand]) begin
        found       = 1'b1;
        grant_idx_o = cand;
      end
    end
  end

  assign grant_valid_o = found;
  assign grant_o       = found ? (NUM_CH'(1) << grant_idx_o) : '0;

  // Pointer moves just past the winner; it holds when nothing is granted.
  always_comb begin
    ptr_d = ptr_q;
    if (found) begin
      if (int'(grant_idx_o) == NUM_CH - 1) ptr_d = '0;
      else                                 ptr_d = grant_idx_o + IDX_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

endmodule

// File: rtl/difftest_trigger_csr_queue.sv
// rtl/difftest_trigger_csr_queue.sv - buffered multi-channel capture of trigger-CSR difftest snapshots
//
// Each channel owns one pending slot loaded by its capture strobe. A round-robin
// arbiter moves one pending slot per cycle into a shared circular FIFO, which is
// drained through a valid/ready port. Overwriting a still-pending slot is counted.
//
// Optional feature macro: TRIGGER_CSR_DEDUP_EN
//   defined   - a capture whose {tselect,tdata1,tinfo} equals the channel's last
//               captured payload is ignored (after the first capture)
//   undefined - every strobe captures
//
// Ports:
//   clock, reset_n                        clock, asynchronous active-low reset
//   in_enable[NUM_CH]                     per-channel capture strobe
//   in_tselect/in_tdata1/in_tinfo         per-channel payload, channel c at [c*DATA_W +: DATA_W]
//   in_coreid                             per-channel core id, channel c at [c*CORE_W +: CORE_W]
//   out_valid/out_ready                   FIFO head handshake
//   out_tselect/out_tdata1/out_tinfo      head payload
//   out_coreid, out_chan                  head core id and source channel
//   drop_count                            saturating count of overwritten pending snapshots
//   overflow                              sticky drop flag
module difftest_trigger_csr_queue
  import difftest_trigger_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64,
  parameter int CORE_W = 8,
  localparam int CHAN_W = chan_idx_w(NUM_CH)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NUM_CH-1:0]        in_enable,
  input  logic [NUM_CH*DATA_W-1:0] in_tselect,
  input  logic [NUM_CH*DATA_W-1:0] in_tdata1,
  input  logic [NUM_CH*DATA_W-1:0] in_tinfo,
  input  logic [NUM_CH*CORE_W-1:0] in_coreid,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_tselect,
  output logic [DATA_W-1:0]        out_tdata1,
  output logic [DATA_W-1:0]        out_tinfo,
  output logic [CORE_W-1:0]        out_coreid,
  output logic [CHAN_W-1:0]        out_chan,
  output logic [DROP_CNT_W-1:0]    drop_count,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [DATA_W-1:0] tselect;
    logic [DATA_W-1:0] tdata1;
    logic [DATA_W-1:0] tinfo;
    logic [CORE_W-1:0] coreid;
  } snap_t;

  // Incoming snapshots, unpacked per channel
  snap_t in_snap [NUM_CH];

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      in_snap[c].tselect = in_tselect[c*DATA_W +: DATA_W];
      in_snap[c].tdata1  = in_tdata1[c*DATA_W +: DATA_W];
      in_snap[c].tinfo   = in_tinfo[c*DATA_W +: DATA_W];
      in_snap[c].coreid  = in_coreid[c*CORE_W +: CORE_W];
    end
  end

  // Effective capture strobes
  logic [NUM_CH-1:0] cap;

`ifdef TRIGGER_CSR_DEDUP_EN
  logic [3*DATA_W-1:0] last_q [NUM_CH];
  logic [NUM_CH-1:0]   seen_q;

  // coreid is deliberately excluded from the comparison: it is fixed per hart.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      cap[c] = in_enable[c] &&
               !(seen_q[c] &&
                 (last_q[c] == {in_snap[c].tselect, in_snap[c].tdata1, in_snap[c].tinfo}));
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      seen_q <= '0;
      for (int c = 0; c < NUM_CH; c++) last_q[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (cap[c]) begin
          last_q[c] <= {in_snap[c].tselect, in_snap[c].tdata1, in_snap[c].tinfo};
          seen_q[c] <= 1'b1;
        end
      end
    end
  end
`else
  assign cap = in_enable;
`endif

  // FIFO bookkeeping
  snap_t             mem_q      [DEPTH];
  logic [CHAN_W-1:0] chan_mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push, pop, can_accept;

  // Arbiter
  logic [NUM_CH-1:0] grant;
  logic [CHAN_W-1:0] grant_idx;
  logic              grant_valid;

  // Pending slots
  logic [NUM_CH-1:0] pend_q, pend_d;
  snap_t             slot_q [NUM_CH];
  snap_t             slot_d [NUM_CH];
  logic [NUM_CH-1:0] drop_vec;

  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d, drops_now;
  logic                  overflow_q, overflow_d;

  assign out_valid  = (count_q != '0);
  assign pop        = out_valid && out_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign can_accept = (count_q < CNT_W'(DEPTH)) || pop;
  assign push       = grant_valid;

  difftest_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (CHAN_W)
  ) u_arb (
    .clock         (clock),
    .reset_n       (reset_n),
    .req_i         (pend_q),
    .en_i          (can_accept),
    .grant_o       (grant),
    .grant_idx_o   (grant_idx),
    .grant_valid_o (grant_valid)
  );

  // A grant drains the slot; a capture in the same cycle refills it without a
  // drop because the old value is leaving for the FIFO.
  always_comb begin
    pend_d   = pend_q;
    slot_d   = slot_q;
    drop_vec = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant[c]) pend_d[c] = 1'b0;
      if (cap[c]) begin
        drop_vec[c] = pend_q[c] && !grant[c];
        pend_d[c]   = 1'b1;
        slot_d[c]   = in_snap[c];
      end
    end
  end

  // Several channels may drop in one cycle; each counts.
  always_comb begin
    drops_now = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      drops_now = drops_now + DROP_CNT_W'(drop_vec[c]);
    end
  end

  assign drop_cnt_d = sat_add(drop_cnt_q, drops_now);
  assign overflow_d = overflow_q | (|drop_vec);

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push && pop) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) slot_q[c] <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i]      <= '0;
        chan_mem_q[i] <= '0;
      end
    end else begin
      pend_q     <= pend_d;
      slot_q     <= slot_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
      if (push) begin
        mem_q[wr_ptr_q]      <= slot_q[grant_idx];
        chan_mem_q[wr_ptr_q] <= grant_idx;
      end
    end
  end

  // Head entry drives the outputs directly; it cannot change until popped.
  assign out_tselect = mem_q[rd_ptr_q].tselect;
  assign out_tdata1  = mem_q[rd_ptr_q].tdata1;
  assign out_tinfo   = mem_q[rd_ptr_q].tinfo;
  assign out_coreid  = mem_q[rd_ptr_q].coreid;
  assign out_chan    = chan_mem_q[rd_ptr_q];
  assign drop_count  = drop_cnt_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_difftest_trigger_csr_queue.sv
// tb/tb_difftest_trigger_csr_queue.sv - randomized and directed bench with a queue-based reference model
module tb_difftest_trigger_csr_queue;

  localparam int NUM_CH = 2;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 64;
  localparam int CORE_W = 8;
  localparam int CHAN_W = 1;

  logic                     clock;
  logic                     reset_n;
  logic [NUM_CH-1:0]        in_enable;
  logic [NUM_CH*DATA_W-1:0] in_tselect, in_tdata1, in_tinfo;
  logic [NUM_CH*CORE_W-1:0] in_coreid;
  logic                     out_valid, out_ready;
  logic [DATA_W-1:0]        out_tselect, out_tdata1, out_tinfo;
  logic [CORE_W-1:0]        out_coreid;
  logic [CHAN_W-1:0]        out_chan;
  logic [31:0]              drop_count;
  logic                     overflow;

  int checks = 0;
  int errors = 0;

  difftest_trigger_csr_queue #(
    .NUM_CH (NUM_CH), .DEPTH (DEPTH), .DATA_W (DATA_W), .CORE_W (CORE_W)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_enable   (in_enable),
    .in_tselect  (in_tselect),
    .in_tdata1   (in_tdata1),
    .in_tinfo    (in_tinfo),
    .in_coreid   (in_coreid),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_tselect (out_tselect),
    .out_tdata1  (out_tdata1),
    .out_tinfo   (out_tinfo),
    .out_coreid  (out_coreid),
    .out_chan    (out_chan),
    .drop_count  (drop_count),
    .overflow    (overflow)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference model: per-channel pending slot, FIFO as a queue
  typedef struct {
    logic [63:0] ts;
    logic [63:0] td;
    logic [63:0] ti;
    logic [7:0]  cid;
    int          chan;
  } ent_t;

  ent_t   m_fifo[$];
  ent_t   m_slot[NUM_CH];
  bit     m_pend[NUM_CH];
  int     m_rr;
  longint m_drops;
  logic [191:0] m_last[NUM_CH];
  bit           m_seen[NUM_CH];

  function automatic ent_t in_ent(int c);
    ent_t e;
    e.ts   = in_tselect[c*DATA_W +: DATA_W];
    e.td   = in_tdata1[c*DATA_W +: DATA_W];
    e.ti   = in_tinfo[c*DATA_W +: DATA_W];
    e.cid  = in_coreid[c*CORE_W +: CORE_W];
    e.chan = c;
    return e;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_fifo.delete();
      for (int c = 0; c < NUM_CH; c++) begin
        m_pend[c] = 0;
        m_seen[c] = 0;
      end
      m_rr    = 0;
      m_drops = 0;
    end else begin
      bit   pop, can, take;
      int   g;
      ent_t e;
      pop = (m_fifo.size() > 0) && out_ready;
      can = (m_fifo.size() < DEPTH) || pop;
      g   = -1;
      if (can) begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (g < 0 && m_pend[(m_rr + k) % NUM_CH]) g = (m_rr + k) % NUM_CH;
        end
      end
      if (pop) void'(m_fifo.pop_front());
      if (g >= 0) begin
        e      = m_slot[g];
        e.chan = g;
        m_fifo.push_back(e);
        m_pend[g] = 0;
        m_rr      = (g + 1) % NUM_CH;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (in_enable[c]) begin
          e    = in_ent(c);
          take = 1;
`ifdef TRIGGER_CSR_DEDUP_EN
          if (m_seen[c] && m_last[c] == {e.ts, e.td, e.ti}) take = 0;
          if (take) begin
            m_last[c] = {e.ts, e.td, e.ti};
            m_seen[c] = 1;
          end
`endif
          if (take) begin
            if (m_pend[c]) m_drops++;
            m_slot[c] = e;
            m_pend[c] = 1;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clock) begin
    longint exp_drops;
    exp_drops = (m_drops > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_drops;
    chk("model out_valid", 64'(out_valid), 64'(m_fifo.size() > 0));
    if (m_fifo.size() > 0) begin
      chk("model out_tselect", out_tselect, m_fifo[0].ts);
      chk("model out_tdata1", out_tdata1, m_fifo[0].td);
      chk("model out_tinfo", out_tinfo, m_fifo[0].ti);
      chk("model out_coreid", 64'(out_coreid), 64'(m_fifo[0].cid));
      chk("model out_chan", 64'(out_chan), 64'(m_fifo[0].chan));
    end
    chk("model drop_count", 64'(drop_count), exp_drops);
    chk("model overflow", 64'(overflow), 64'(m_drops > 0));
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic set_ch(input int c, input bit en, input logic [63:0] ts,
                        input logic [63:0] td, input logic [63:0] ti, input logic [7:0] cid);
    in_enable[c]                  = en;
    in_tselect[c*DATA_W +: DATA_W] = ts;
    in_tdata1[c*DATA_W +: DATA_W]  = td;
    in_tinfo[c*DATA_W +: DATA_W]   = ti;
    in_coreid[c*CORE_W +: CORE_W]  = cid;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int exp_seq[5];
    int pops;
    reset_n    = 1'b0;
    in_enable  = '0;
    in_tselect = '0;
    in_tdata1  = '0;
    in_tinfo   = '0;
    in_coreid  = '0;
    out_ready  = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;

    // Reset state
    @(negedge clock);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset drop_count", 64'(drop_count), 64'd0);
    chk("reset out_tdata1", out_tdata1, 64'd0);

    // Single capture, two-cycle latency
    tick();
    out_ready = 1'b1;
    set_ch(0, 1, 64'h0, 64'h1234, 64'h0, 8'h0);
    tick();
    set_ch(0, 0, 64'h0, 64'h0, 64'h0, 8'h0);
    tick();
    @(negedge clock);
    chk("lat out_valid", 64'(out_valid), 64'd1);
    chk("lat out_tdata1", out_tdata1, 64'h1234);
    chk("lat out_chan", 64'(out_chan), 64'd0);
    chk("lat drop_count", 64'(drop_count), 64'd0);
    tick();
    tick();

    // Simultaneous pair: pointer sits at 1 after the ch0 grant above
    set_ch(0, 1, 64'd1, 64'h0, 64'h0, 8'h0);
    set_ch(1, 1, 64'd2, 64'h0, 64'h0, 8'h1);
    tick();
    in_enable = '0;
    tick();
    @(negedge clock);
    chk("rr first chan", 64'(out_chan), 64'd1);
    chk("rr first tselect", out_tselect, 64'd2);
    tick();
    @(negedge clock);
    chk("rr second chan", 64'(out_chan), 64'd0);
    chk("rr second tselect", out_tselect, 64'd1);
    tick();
    tick();

    // Back-pressure: six captures into a depth-4 FIFO
    out_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      set_ch(0, 1, 64'(k), 64'h0, 64'h0, 8'h0);
      tick();
    end
    in_enable = '0;
    @(negedge clock);
    chk("full drop_count", 64'(drop_count), 64'd1);
    chk("full overflow", 64'(overflow), 64'd1);
    tick();
    out_ready = 1'b1;
    exp_seq = '{1, 2, 3, 4, 6};
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("drain order", out_tselect, 64'(exp_seq[i]));
    end
    chk("drain no new drop", 64'(drop_count), 64'd1);
    tick();
    tick();

    // Five drops, then asynchronous reset mid-operation
    do_reset();
    out_ready = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      set_ch(0, 1, 64'(k), 64'h0, 64'h0, 8'h0);
      tick();
    end
    in_enable = '0;
    @(negedge clock);
    chk("pre-reset drop_count", 64'(drop_count), 64'd5);
    chk("pre-reset out_valid", 64'(out_valid), 64'd1);
    tick();
    reset_n = 1'b0;
    #1;
    chk("async reset out_valid", 64'(out_valid), 64'd0);
    chk("async reset drop_count", 64'(drop_count), 64'd0);
    chk("async reset overflow", 64'(overflow), 64'd0);
    tick();
    reset_n = 1'b1;
    tick();

`ifdef TRIGGER_CSR_DEDUP_EN
    // Duplicate payload is ignored; the first all-zero snapshot is still taken
    out_ready = 1'b0;
    set_ch(0, 1, 64'h0, 64'h0, 64'h0, 8'h0);
    tick();
    tick();
    set_ch(0, 1, 64'h0, 64'h0, 64'h0, 8'h0);
    tick();
    set_ch(0, 1, 64'h0, 64'h0, 64'h5, 8'h0);
    tick();
    in_enable = '0;
    tick();
    tick();
    out_ready = 1'b1;
    pops = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (out_valid) pops++;
    end
    chk("dedup pop count", 64'(pops), 64'd2);
    tick();
`endif

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      tick();
      if ($urandom_range(0, 599) == 0) reset_n = 1'b0;
      else                             reset_n = 1'b1;
      for (int c = 0; c < NUM_CH; c++) begin
        set_ch(c, ($urandom_range(0, 9) < 4),
               64'($urandom_range(0, 3)),
               {32'($urandom), 32'($urandom_range(0, 1))},
               64'($urandom_range(0, 2)),
               8'($urandom));
      end
      out_ready = ($urandom_range(0, 9) < 6);
    end
    reset_n   = 1'b1;
    in_enable = '0;
    out_ready = 1'b1;
    for (int n = 0; n < 12; n++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
